// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: operand widths, fixed-point formats and
// the sample/coefficient types used by the butterfly and twiddle stages.
package fft_pkg;

  // Data samples are Q8.8 two's complement
  localparam int DATA_W    = 16;
  localparam int DIN_FRAC  = 8;

  // Twiddle coefficients are Q2.14 two's complement
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;

  // Full-precision product width (Q10.22)
  localparam int PROD_W    = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

endpackage : fft_pkg

// File: rtl/fx_rescale_sat.sv
// Combinational rescale of a full-precision signed product back to the
// sample format. Arithmetic right shift by SHIFT (truncation toward -inf),
// overflow detection on the guard bits above the result field, and optional
// clamping selected by the SIGNED_MULT_SAT_EN macro (undefined: wrap).
module fx_rescale_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  prod_i,
  output logic        [OUT_W-1:0] res_o,
  output logic                    ovf_o
);

  // Index of the result sign bit inside the product
  localparam int TOP     = SHIFT + OUT_W - 1;
  // Number of product bits above the result sign bit
  localparam int N_GUARD = IN_W - 1 - TOP;

  localparam logic [OUT_W-1:0] RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [N_GUARD-1:0] guard_diff;
  logic [OUT_W-1:0]   res_wrap;
  logic               prod_sign;
  logic               unused_lsb;

  // Each guard bit must equal the product sign for the result to fit
  for (genvar gi = 0; gi < N_GUARD; gi++) begin : g_guard
    assign guard_diff[gi] = prod_i[TOP + gi] ^ prod_i[IN_W-1];
  end

  assign prod_sign  = prod_i[IN_W-1];
  assign res_wrap   = prod_i[TOP:SHIFT];
  // Fraction bits below the result field are discarded by truncation
  assign unused_lsb = ^prod_i[SHIFT-1:0];

  // Overflow flag and result selection (clamp or wrap)
  always_comb begin
    ovf_o = |guard_diff;
`ifdef SIGNED_MULT_SAT_EN
    if (ovf_o) begin
      res_o = prod_sign ? RES_MIN : RES_MAX;
    end else begin
      res_o = res_wrap;
    end
`else
    res_o = res_wrap;
`endif
  end

endmodule : fx_rescale_sat

// File: rtl/signed_multiplier_fx.sv
// Registered signed fixed-point multiplier for the FFT twiddle path.
// Q8.8 sample times Q2.14 coefficient, result rescaled to Q8.8.
// Two-stage pipeline: operand registers, then rescaled product registers.
// Optional saturation on overflow: define SIGNED_MULT_SAT_EN.
module signed_multiplier_fx
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [COEF_W-1:0] W,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              ovf
);

  // Stage 1: operands and valid
  sample_t din_q, din_d;
  coef_t   w_q,   w_d;
  logic    v1_q,  v1_d;

  // Stage 2: rescaled result, overflow flag and valid
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q,  ovf_d;
  logic              v2_q,   v2_d;

  // Combinational product path between the stages
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        res;
  logic                     res_ovf;

  // Stage 1 next state: operands load only on a valid strobe, valid always moves
  always_comb begin
    din_d = din_q;
    w_d   = w_q;
    v1_d  = in_valid;
    if (in_valid) begin
      din_d = $signed(din);
      w_d   = $signed(W);
    end
  end

  // Stage 1 registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= '0;
      w_q   <= '0;
      v1_q  <= 1'b0;
    end else begin
      din_q <= din_d;
      w_q   <= w_d;
      v1_q  <= v1_d;
    end
  end

  // Full-precision signed product, Q10.22
  assign prod = PROD_W'(din_q) * PROD_W'(w_q);

  fx_rescale_sat #(
    .IN_W  (PROD_W),
    .OUT_W (DATA_W),
    .SHIFT (COEF_FRAC)
  ) u_rescale (
    .prod_i (prod),
    .res_o  (res),
    .ovf_o  (res_ovf)
  );

  // Stage 2 next state: result loads only when stage 1 holds a valid sample,
  // so dout/ovf keep their last value across bubbles
  always_comb begin
    dout_d = dout_q;
    ovf_d  = ovf_q;
    v2_d   = v1_q;
    if (v1_q) begin
      dout_d = res;
      ovf_d  = res_ovf;
    end
  end

  // Stage 2 registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      v2_q   <= v2_d;
    end
  end

  assign out_valid = v2_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule : signed_multiplier_fx

// File: tb/tb_signed_multiplier_fx.sv
// Directed bench for signed_multiplier_fx. Expected results are hand-computed
// Q8.8 values; the overflow vectors pick clamp or wrap values depending on
// SIGNED_MULT_SAT_EN.
module tb_signed_multiplier_fx;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] din;
  logic [15:0] W;
  logic        out_valid;
  logic [15:0] dout;
  logic        ovf;

  signed_multiplier_fx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din       (din),
    .W         (W),
    .out_valid (out_valid),
    .dout      (dout),
    .ovf       (ovf)
  );

`ifdef SIGNED_MULT_SAT_EN
  localparam logic [15:0] EXP_NEG128_X_NEG1 = 16'h7FFF;
  localparam logic [15:0] EXP_NEG128_X_MAXW = 16'h8000;
  localparam logic [15:0] EXP_MAXD_X_MAXW   = 16'h7FFF;
`else
  localparam logic [15:0] EXP_NEG128_X_NEG1 = 16'h8000;
  localparam logic [15:0] EXP_NEG128_X_MAXW = 16'h0002;
  localparam logic [15:0] EXP_MAXD_X_MAXW   = 16'hFFFC;
`endif

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one input cycle; valid samples are queued with their due edge
  task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] w,
                       input logic [15:0] ed, input logic eo);
    @(negedge clk);
    in_valid = v;
    din      = d;
    W        = w;
    if (v && rst_n) sb.push_back('{d: ed, o: eo, due: cyc + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'($urandom), 16'($urandom), 16'h0, 1'b0);
    end
  endtask

  // Output monitor: checks every edge against the scoreboard
  initial begin
    logic        r;
    logic        exp_v;
    logic [15:0] last_d;
    logic        last_o;
    last_d = 16'h0;
    last_o = 1'b0;
    forever begin
      @(posedge clk);
      r = rst_n;
      cyc++;
      #1;
      if (!r) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        sb.delete();
        last_d = 16'h0;
        last_o = 1'b0;
      end else begin
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
          $display("out cycle=%0d dout=%h ovf=%b (exp %h/%b)", cyc, dout, ovf, sb[0].d, sb[0].o);
          check("dout", 32'(dout), 32'(sb[0].d));
          check("ovf", 32'(ovf), 32'(sb[0].o));
          last_d = sb[0].d;
          last_o = sb[0].o;
          void'(sb.pop_front());
        end else begin
          check("hold_dout", 32'(dout), 32'(last_d));
          check("hold_ovf", 32'(ovf), 32'(last_o));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = 16'h0;
    W        = 16'h0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Isolated vectors
    drive(1'b1, 16'h0400, 16'h4000, 16'h0400, 1'b0); idle(3);
    drive(1'b1, 16'h0400, 16'h3FFF, 16'h03FF, 1'b0); idle(3);
    drive(1'b1, 16'h0400, 16'hC000, 16'hFC00, 1'b0); idle(3);
    drive(1'b1, 16'hFC00, 16'hC000, 16'h0400, 1'b0); idle(3);
    drive(1'b1, 16'hBC00, 16'hE000, 16'h2200, 1'b0); idle(3);
    drive(1'b1, 16'hF600, 16'hF800, 16'h0140, 1'b0); idle(3);
    drive(1'b1, 16'h0001, 16'hE000, 16'hFFFF, 1'b0); idle(3);

    // Back-to-back stream with a one-cycle gap, including range boundaries
    drive(1'b1, 16'h8000, 16'hC000, EXP_NEG128_X_NEG1, 1'b1);
    drive(1'b1, 16'h8000, 16'h4000, 16'h8000, 1'b0);
    drive(1'b1, 16'h7FFF, 16'h4000, 16'h7FFF, 1'b0);
    drive(1'b1, 16'h8000, 16'h7FFF, EXP_NEG128_X_MAXW, 1'b1);
    idle(1);
    drive(1'b1, 16'h7FFF, 16'h7FFF, EXP_MAXD_X_MAXW, 1'b1);
    drive(1'b1, 16'h0400, 16'h4000, 16'h0400, 1'b0);
    idle(4);

    // Reset with two samples in flight: neither may be emitted
    drive(1'b1, 16'hBC00, 16'hE000, 16'h2200, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    din      = 16'h0400;
    W        = 16'hC000;
    rst_n    = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    din      = 16'h7FFF;
    W        = 16'h7FFF;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(3);

    // First sample after reset release
    drive(1'b1, 16'h0400, 16'hC000, 16'hFC00, 1'b0);
    idle(5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_signed_multiplier_fx
